// File: rtl/nco_capture_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nco_capture_writer: decimates NCO I/Q samples, packs two per 64-bit word |
// | and writes them to on-chip memory port s2.           Revision: 1.0       |
// +--------------------------------------------------------------------------+
module nco_capture_writer #(
  parameter int ADDR_W = 14,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [35:0]       nco_out_data,
  input  logic              nco_out_valid,
  input  logic              arm,
  input  logic              trig,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] num_words,
  input  logic [7:0]        decim,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [63:0]       mem_writedata,
  output logic [7:0]        mem_byteenable,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_written
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [LEN_W-1:0]  r_target;
  logic [7:0]        r_decim;
  logic [7:0]        r_dcnt;
  logic              r_half;
  logic [31:0]       r_lo;

  logic              w_arm;
  logic              w_accept;
  logic              w_keep;
  logic              w_complete;
  logic              w_last;
  logic [LEN_W-1:0]  w_words_inc;
  logic [31:0]       w_sample;
  logic              w_unused_bits;

  assign w_sample    = {nco_out_data[35:20], nco_out_data[17:2]};
  // Truncated LSBs are intentionally dropped.
  assign w_unused_bits = ^{nco_out_data[19:18], nco_out_data[1:0]};

  assign w_arm       = arm && !abort && (r_state == ST_IDLE);
  assign w_accept    = nco_out_valid && !abort &&
                       ((r_state == ST_CAPTURE) || ((r_state == ST_ARMED) && trig));
  assign w_keep      = w_accept && (r_dcnt == 8'd0);
  assign w_complete  = w_keep && r_half;
  assign w_words_inc = words_written + LEN_W'(1);
  assign w_last      = w_complete && (w_words_inc == r_target);

  assign mem_clken   = 1'b1;
  assign busy        = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (arm)    w_state_nxt = ST_ARMED;
        ST_ARMED:   if (trig)   w_state_nxt = ST_CAPTURE;
        ST_CAPTURE: if (w_last) w_state_nxt = ST_IDLE;
        default:                w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_ptr          <= '0;
      r_target       <= '0;
      r_decim        <= 8'd0;
      r_dcnt         <= 8'd0;
      r_half         <= 1'b0;
      r_lo           <= 32'd0;
      mem_address    <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= 64'd0;
      mem_byteenable <= 8'd0;
      done           <= 1'b0;
      words_written  <= '0;
    end else begin
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_byteenable <= 8'd0;
      if (abort) begin
        r_half <= 1'b0;
        r_dcnt <= 8'd0;
      end else if (w_arm) begin
        r_ptr         <= start_addr;
        // A zero length requests the whole memory.
        r_target      <= (num_words == '0) ? (LEN_W'(1) << ADDR_W) : LEN_W'(num_words);
        r_decim       <= decim;
        r_dcnt        <= 8'd0;
        r_half        <= 1'b0;
        done          <= 1'b0;
        words_written <= '0;
      end else if (w_accept) begin
        r_dcnt <= (r_dcnt == r_decim) ? 8'd0 : r_dcnt + 8'd1;
        if (w_keep) begin
          if (!r_half) begin
            r_lo   <= w_sample;
            r_half <= 1'b1;
          end else begin
            r_half         <= 1'b0;
            mem_address    <= r_ptr;
            mem_writedata  <= {w_sample, r_lo};
            mem_chipselect <= 1'b1;
            mem_write      <= 1'b1;
            mem_byteenable <= 8'hFF;
            r_ptr          <= r_ptr + ADDR_W'(1);
            words_written  <= w_words_inc;
            if (w_last) begin
              done <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nco_capture_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nco_capture_writer: directed bench with write scoreboard.             |
// |                                                      Revision: 1.0       |
// +--------------------------------------------------------------------------+
module tb_nco_capture_writer;

  localparam int AW = 14;
  localparam int LW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [35:0]   data;
  logic          valid, arm, trig, abort;
  logic [AW-1:0] start_addr, num_words;
  logic [7:0]    decim;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect, mem_clken, mem_write;
  logic [63:0]   mem_writedata;
  logic [7:0]    mem_byteenable;
  logic          busy, done;
  logic [LW-1:0] words_written;

  typedef struct {
    logic [AW-1:0] a;
    logic [63:0]   d;
    int            c;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   nchk  = 0;
  int   npass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  nco_capture_writer #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .nco_out_data   (data),
    .nco_out_valid  (valid),
    .arm            (arm),
    .trig           (trig),
    .abort          (abort),
    .start_addr     (start_addr),
    .num_words      (num_words),
    .decim          (decim),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .busy           (busy),
    .done           (done),
    .words_written  (words_written)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endtask

  // Sample k: cos = {k,2'b11}, sin = {1,k[14:0],2'b01}; truncation keeps {k, 1,k[14:0]}.
  function automatic logic [35:0] mk(input int k);
    logic [15:0] v;
    v = 16'(k);
    return {v, 2'b11, 1'b1, v[14:0], 2'b01};
  endfunction

  function automatic logic [31:0] tr(input int k);
    logic [15:0] v;
    v = 16'(k);
    return {v, 16'h8000 | v};
  endfunction

  always @(negedge clk) begin
    if (mem_write || mem_chipselect || (mem_byteenable != 8'd0)) begin
      if (q.size() == 0) begin
        nchk++;
        $display("FAIL unexpected_write: got write at addr %h cycle %0d, required none", mem_address, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr",  64'(mem_address), 64'(e.a));
        chk("wr_data",  mem_writedata, e.d);
        chk("wr_be",    64'(mem_byteenable), 64'hFF);
        chk("wr_cs_we", 64'({mem_chipselect, mem_write}), 64'h3);
        chk("wr_cycle", 64'(cyc), 64'(e.c));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [AW-1:0] sa, input logic [AW-1:0] nw, input logic [7:0] dc);
    start_addr = sa;
    num_words  = nw;
    decim      = dc;
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
  endtask

  task automatic run_valid(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      valid = 1'b1;
      data  = mk(base + i);
      tick();
    end
    valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    tick();
    tick();
    chk(nm, 64'(q.size()), 64'd0);
  endtask

  // Arms, triggers on the first cycle, and drives nsmp valid samples every gap+1 cycles.
  task automatic capture(input logic [AW-1:0] sa, input int nw, input int dc,
                         input int gap, input int nsmp);
    int          k;
    int          kept;
    int          words;
    logic [31:0] lo;
    k = 0; kept = 0; words = 0; lo = '0;
    do_arm(sa, AW'(nw), 8'(dc));
    chk("armed_busy", 64'(busy), 64'd1);
    for (int c = 0; k < nsmp; c++) begin
      valid = ((c % (gap + 1)) == 0);
      trig  = (c == 0);
      if (valid) begin
        data = mk(k);
        if (words < nw && (k % (dc + 1)) == 0) begin
          if ((kept % 2) == 0) lo = tr(k);
          else begin
            q.push_back('{a: sa + AW'(words), d: {tr(k), lo}, c: cyc + 1});
            words++;
          end
          kept++;
        end
        k++;
      end
      tick();
    end
    valid = 1'b0;
    trig  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; arm = 1'b0; trig = 1'b0; abort = 1'b0;
    data = '0; start_addr = '0; num_words = '0; decim = '0;
    tick();
    tick();
    chk("rst_addr",  64'(mem_address), 64'd0);
    chk("rst_wdata", mem_writedata, 64'd0);
    chk("rst_strb",  64'({mem_chipselect, mem_write, mem_byteenable}), 64'd0);
    chk("rst_clken", 64'(mem_clken), 64'd1);
    chk("rst_stat",  64'({busy, done, words_written}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic 4-word capture; extra samples afterwards must be ignored.
    capture(14'h0100, 4, 0, 0, 8);
    chk("t1_done",  64'(done), 64'd1);
    chk("t1_busy",  64'(busy), 64'd0);
    chk("t1_words", 64'(words_written), 64'd4);
    run_valid(4, 100);
    chk("t1_words_hold", 64'(words_written), 64'd4);
    drain("t1_drain");

    // Address wrap at the top of memory.
    capture(14'h3FFE, 3, 0, 0, 6);
    chk("t2_done",  64'(done), 64'd1);
    chk("t2_words", 64'(words_written), 64'd3);
    drain("t2_drain");

    // Decimation by 3: samples 0,3,6,9 kept.
    capture(14'h0400, 2, 2, 0, 10);
    chk("t3_done",  64'(done), 64'd1);
    chk("t3_words", 64'(words_written), 64'd2);
    drain("t3_drain");

    // Gapped valid, one sample every 4 cycles.
    capture(14'h0500, 2, 0, 3, 4);
    chk("t4_done",  64'(done), 64'd1);
    chk("t4_words", 64'(words_written), 64'd2);
    drain("t4_drain");

    // Abort after 1.5 words; abort coincides with the would-be completing sample.
    do_arm(14'h0200, 14'd4, 8'd0);
    for (int k = 0; k < 3; k++) begin
      valid = 1'b1; trig = (k == 0); data = mk(k);
      if (k == 1) q.push_back('{a: 14'h0200, d: {tr(1), tr(0)}, c: cyc + 1});
      tick();
    end
    trig = 1'b0; abort = 1'b1; data = mk(3);
    tick();
    abort = 1'b0;
    chk("t5_busy",  64'(busy), 64'd0);
    chk("t5_done",  64'(done), 64'd0);
    chk("t5_words", 64'(words_written), 64'd1);
    run_valid(3, 4);
    drain("t5_drain");
    do_arm(14'h0200, 14'd4, 8'd0);
    chk("t5_rearm_words", 64'(words_written), 64'd0);
    chk("t5_rearm_busy",  64'(busy), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_idle", 64'(busy), 64'd0);

    // arm+trig+abort together stays idle.
    arm = 1'b1; trig = 1'b1; abort = 1'b1; valid = 1'b1; data = mk(0);
    tick();
    arm = 1'b0; abort = 1'b0;
    chk("t6_idle", 64'(busy), 64'd0);
    run_valid(3, 1);
    trig = 1'b0;
    drain("t6_drain");

    // arm during CAPTURE is ignored.
    do_arm(14'h0300, 14'd2, 8'd0);
    for (int k = 0; k < 4; k++) begin
      valid = 1'b1; trig = (k == 0); data = mk(k);
      arm = (k == 1);
      if (k == 1) begin start_addr = 14'h1000; num_words = 14'd8; end
      if (k == 1) q.push_back('{a: 14'h0300, d: {tr(1), tr(0)}, c: cyc + 1});
      if (k == 3) q.push_back('{a: 14'h0301, d: {tr(3), tr(2)}, c: cyc + 1});
      tick();
    end
    arm = 1'b0; trig = 1'b0; valid = 1'b0;
    chk("t6_done",  64'(done), 64'd1);
    chk("t6_words", 64'(words_written), 64'd2);
    run_valid(3, 50);
    drain("t6b_drain");

    // Reset mid-capture with a half word pending.
    do_arm(14'h0600, 14'd4, 8'd0);
    for (int k = 0; k < 3; k++) begin
      valid = 1'b1; trig = (k == 0); data = mk(k);
      if (k == 1) q.push_back('{a: 14'h0600, d: {tr(1), tr(0)}, c: cyc + 1});
      tick();
    end
    trig = 1'b0; data = mk(3);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_stat", 64'({busy, done, words_written}), 64'd0);
    chk("t7_rst_addr", 64'(mem_address), 64'd0);
    tick();
    rst_n = 1'b1;
    run_valid(4, 4);
    chk("t7_post_busy", 64'(busy), 64'd0);
    drain("t7_drain");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nco_capture_writer.md
Name: nco_capture_writer

Overview:
Sits directly downstream of the NCO in the cinnabon system. It consumes the NCO sample stream (36-bit out_data/out_valid), optionally decimates it, and packs two truncated I/Q samples into each 64-bit word. It writes those words through the on-chip memory second port (s2), giving the PCIe host a captured snapshot to read back. Host software controls the block through arm/trigger/abort strobes and reads busy/done/word-count status.

Parameters:
ADDR_W, 14, on-chip memory s2 word-address width
LEN_W, 15, capture length/count width (ADDR_W+1)

Ports:
clk_clk  in  1  system clock; all logic is on the rising edge
reset_reset_n  in  1  asynchronous, active-low reset
nco_out_data  in  36  NCO sample; [35:18] = cos, [17:0] = sin, signed 18-bit
nco_out_valid  in  1  sample qualifier; no backpressure is possible
arm  in  1  single-cycle strobe: load config and enter ARMED
trig  in  1  capture start strobe; sampled only in ARMED
abort  in  1  strobe: return to IDLE immediately
start_addr  in  ADDR_W  first word address; latched on arm
num_words  in  ADDR_W  words to capture; 0 means 2^ADDR_W; latched on arm
decim  in  8  keep 1 of every decim+1 valid samples; latched on arm
mem_address  out  ADDR_W  to onchip_memory_s2_address
mem_chipselect  out  1  to onchip_memory_s2_chipselect
mem_clken  out  1  to onchip_memory_s2_clken; constant 1
mem_write  out  1  to onchip_memory_s2_write
mem_writedata  out  64  to onchip_memory_s2_writedata
mem_byteenable  out  8  to onchip_memory_s2_byteenable
busy  out  1  high in ARMED or CAPTURE
done  out  1  sticky; capture completed normally
words_written  out  LEN_W  words written since the last arm

Behaviour:
- Reset (async assert, sync release): state=IDLE; mem_address=0; mem_chipselect=0; mem_write=0; mem_writedata=0; mem_byteenable=0; busy=0; done=0; words_written=0; decimation counter=0; half-word flag=0. mem_clken=1 always.
- States: IDLE, ARMED, CAPTURE.
  - IDLE: arm -> ARMED. Latch start_addr, num_words and decim. Clear done and words_written. Zero the decimation counter and half flag.
  - ARMED: trig -> CAPTURE in the same cycle.
  - CAPTURE: last word written -> IDLE with done=1.
  - Any state: abort -> IDLE. abort has priority over arm and trig. The partial packed half is discarded; done stays 0; words_written holds its value.
  - arm outside IDLE is ignored.
- Sample acceptance: a sample is accepted when nco_out_valid=1 and either (state=CAPTURE) or (state=ARMED and trig=1). The trigger-cycle sample is therefore the first candidate.
- Decimation: each accepted sample is kept when the decim counter=0. The counter increments per accepted sample and wraps from the latched decim value to 0. decim=0 keeps every sample.
- Packing: each kept sample is truncated to 32 bits, {cos[17:2], sin[17:2]}. The first kept sample is held in the low half [31:0]. The second goes in [63:32] and completes the word.
- Write timing: the word is completed on the cycle of the second kept sample (cycle N). In cycle N+1, mem_chipselect=1, mem_write=1, mem_byteenable=8'hFF, mem_writedata=packed word and mem_address=current pointer, all registered. All of these strobes are single-cycle; outside write cycles, chipselect, write and byteenable are 0.
- Back-to-back words are possible: a word completes at most every 2 cycles.
- Pointer: starts at the latched start_addr and increments after each write, wrapping from 2^ADDR_W-1 to 0. words_written increments in the write cycle.
- Completion: when words_written reaches the target (num_words, or 2^ADDR_W when num_words=0), the FSM enters IDLE and done=1 in the same cycle the final write is presented. Further samples are ignored.
- busy falls in that same cycle.
- Reset mid-capture: all state is cleared and no write is issued afterward.

Test Plan:
- arm with start_addr=0x0100, num_words=4, decim=0; trig while valid runs continuously with data k = sample index -> 4 writes to 0x0100..0x0103. The word at 0x0100 = {trunc(s1), trunc(s0)}. done=1, words_written=4, busy=0.
- start_addr=0x3FFE, num_words=3 -> writes to addresses 0x3FFE, 0x3FFF, 0x0000 in that order.
- decim=2, num_words=2, valid continuous -> samples 0, 3, 6, 9 are kept. The write-strobe spacing is 6 cycles.
- Gapped valid (1 of every 4 cycles), decim=0, num_words=2 -> each write appears exactly 1 cycle after the second sample of its pair.
- abort issued after 1.5 words -> exactly 1 write occurs, state=IDLE, done=0, words_written=1. A following arm clears words_written to 0.
- arm and trig asserted in the same cycle as abort -> stays in IDLE with no writes. arm while in CAPTURE is ignored and the latched num_words is unchanged.
